// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multi-cycle control + ALU block.
//   State encodings S0..S10, opcode/funct constants, ALUop and ALU control codes,
//   the packed control-strobe bundle and its per-state decode.
//   Optional feature macro used by consumers: MC_ALU_NOR_EN (enables NOR funct).
package mc_pkg;

   localparam int unsigned STATE_W  = 4;
   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned FUNCT_W  = 6;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_LWWB   = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RCOMP  = 4'd7,
      S_BEQ    = 4'd8,
      S_JUMP   = 4'd9,
      S_HALT   = 4'd10
   } state_e;

   localparam logic [OPCODE_W-1:0] OP_R   = 6'd0;
   localparam logic [OPCODE_W-1:0] OP_J   = 6'd2;
   localparam logic [OPCODE_W-1:0] OP_BEQ = 6'd4;
   localparam logic [OPCODE_W-1:0] OP_LW  = 6'd35;
   localparam logic [OPCODE_W-1:0] OP_SW  = 6'd43;

   localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_NOR = 3'b100,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_code_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic       reg_write;
      logic       reg_dst;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic [1:0] alu_src_b;
      logic       finish;
   } ctrl_t;

   // Moore decode: strobes as a function of state only; unlisted strobes stay 0.
   function automatic ctrl_t ctrl_decode(input state_e st);
      ctrl_t c;
      c = '0;
      case (st)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE: c.alu_src_b = 2'b11;
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_LWWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_RCOMP: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = ALUOP_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
         end
         S_HALT:  c.finish = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_ctrl_alu_if.sv
// mc_ctrl_alu_if: datapath <-> controller bundle.
//   master: datapath side (drives IR fields and muxed operands).
//   slave : controller side (drives ALU result, zero, state, finish, strobes, pc_en).
interface mc_ctrl_alu_if #(parameter int unsigned WIDTH = 32);
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_result;
   logic             zero;
   logic [3:0]       state;
   logic             finish;
   logic             pc_write;
   logic             pc_write_cond;
   logic             iord;
   logic             mem_read;
   logic             mem_write;
   logic             ir_write;
   logic             mem_to_reg;
   logic             alu_src_a;
   logic             reg_write;
   logic             reg_dst;
   logic [1:0]       pc_source;
   logic [1:0]       alu_op;
   logic [1:0]       alu_src_b;
   logic             pc_en;

   modport master (
      output opcode, funct, op_a, op_b,
      input  alu_result, zero, state, finish, pc_write, pc_write_cond, iord,
             mem_read, mem_write, ir_write, mem_to_reg, alu_src_a, reg_write,
             reg_dst, pc_source, alu_op, alu_src_b, pc_en
   );

   modport slave (
      input  opcode, funct, op_a, op_b,
      output alu_result, zero, state, finish, pc_write, pc_write_cond, iord,
             mem_read, mem_write, ir_write, mem_to_reg, alu_src_a, reg_write,
             reg_dst, pc_source, alu_op, alu_src_b, pc_en
   );
endinterface

// File: rtl/mc_alu_core.sv
// mc_alu_core: combinational ALU-control decode (alu_op + funct) and ALU datapath.
//   Ports: alu_op, funct, op_a, op_b in; result, zero out.
//   MC_ALU_NOR_EN: when defined, funct 100111 selects NOR; otherwise it falls to add.
module mc_alu_core
   import mc_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   alu_code_e alu_ctrl;

   // ALU control decode; anything unrecognised defaults to add.
   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_ctrl = ALU_ADD;
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_ctrl = ALU_ADD;
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_SLT:  alu_ctrl = ALU_SLT;
`ifdef MC_ALU_NOR_EN
               FN_NOR:  alu_ctrl = ALU_NOR;
`else
               FN_NOR:  alu_ctrl = ALU_ADD;
`endif
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default:   alu_ctrl = ALU_ADD;
      endcase
   end

   // Datapath; add/sub wrap with no overflow reporting, slt is signed.
   always_comb begin
      result = op_a + op_b;
      case (alu_ctrl)
         ALU_AND: result = op_a & op_b;
         ALU_OR:  result = op_a | op_b;
         ALU_SUB: result = op_a - op_b;
         ALU_SLT: result = WIDTH'($signed(op_a) < $signed(op_b));
`ifdef MC_ALU_NOR_EN
         ALU_NOR: result = ~(op_a | op_b);
`endif
         default: result = op_a + op_b;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/mc_ctrl_alu.sv
// mc_ctrl_alu: multi-cycle CPU control FSM plus ALU.
//   Ports: clk, rst_n (async active-low), bus (mc_ctrl_alu_if.slave):
//     in : opcode, funct, op_a, op_b
//     out: alu_result, zero, pc_en (combinational); state, finish and all
//          datapath strobes (registered Moore outputs of the state).
//   Optional: MC_ALU_NOR_EN (handled in mc_alu_core).
module mc_ctrl_alu
   import mc_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   mc_ctrl_alu_if.slave  bus
);

   state_e           state_q, state_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic [WIDTH-1:0] alu_result;
   logic             zero;

   // Next state; strobes are decoded from the next state so the registered
   // copy always matches the current state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXEC;
               OP_BEQ:       state_d = S_BEQ;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_HALT;
            endcase
         end
         S_MEMADR: begin
            if (bus.opcode == OP_LW)      state_d = S_MEMRD;
            else if (bus.opcode == OP_SW) state_d = S_MEMWR;
            else                          state_d = S_FETCH;
         end
         S_MEMRD:  state_d = S_LWWB;
         S_LWWB:   state_d = S_FETCH;
         S_MEMWR:  state_d = S_FETCH;
         S_EXEC:   state_d = S_RCOMP;
         S_RCOMP:  state_d = S_FETCH;
         S_BEQ:    state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
      ctrl_d = ctrl_decode(state_d);
   end

   // State and strobe registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         ctrl_q  <= ctrl_decode(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   mc_alu_core #(.WIDTH(WIDTH)) u_alu (
      .alu_op (ctrl_q.alu_op),
      .funct  (bus.funct),
      .op_a   (bus.op_a),
      .op_b   (bus.op_b),
      .result (alu_result),
      .zero   (zero)
   );

   assign bus.alu_result    = alu_result;
   assign bus.zero          = zero;
   assign bus.state         = state_q;
   assign bus.finish        = ctrl_q.finish;
   assign bus.pc_write      = ctrl_q.pc_write;
   assign bus.pc_write_cond = ctrl_q.pc_write_cond;
   assign bus.iord          = ctrl_q.iord;
   assign bus.mem_read      = ctrl_q.mem_read;
   assign bus.mem_write     = ctrl_q.mem_write;
   assign bus.ir_write      = ctrl_q.ir_write;
   assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
   assign bus.alu_src_a     = ctrl_q.alu_src_a;
   assign bus.reg_write     = ctrl_q.reg_write;
   assign bus.reg_dst       = ctrl_q.reg_dst;
   assign bus.pc_source     = ctrl_q.pc_source;
   assign bus.alu_op        = ctrl_q.alu_op;
   assign bus.alu_src_b     = ctrl_q.alu_src_b;
   assign bus.pc_en         = ctrl_q.pc_write | (ctrl_q.pc_write_cond & zero);

endmodule

// File: tb/tb_mc_ctrl_alu.sv
// tb_mc_ctrl_alu: directed bench for mc_ctrl_alu (state walks, strobes, ALU ops,
// async reset, halt).
module tb_mc_ctrl_alu;
   import mc_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

`ifdef MC_ALU_NOR_EN
   localparam logic [31:0] NOR_EXP = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] NOR_EXP = 32'h0000_0000;
`endif

   mc_ctrl_alu_if bus ();

   mc_ctrl_alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step_state(input string tag, input logic [3:0] exp_state);
      @(negedge clk);
      chk(tag, 32'(bus.state), 32'(exp_state));
   endtask

   // Entry: at a negedge with the FSM in S0. Runs one R-type instruction.
   task automatic r_alu(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic z);
      bus.opcode = OP_R;
      step_state({tag, "_s1"}, 4'd1);
      bus.funct = fn;
      bus.op_a  = a;
      bus.op_b  = b;
      step_state({tag, "_s6"}, 4'd6);
      chk({tag, "_res"}, bus.alu_result, res);
      chk({tag, "_zero"}, 32'(bus.zero), 32'(z));
      step_state({tag, "_s7"}, 4'd7);
      chk({tag, "_reg_write"}, 32'(bus.reg_write), 32'd1);
      chk({tag, "_reg_dst"}, 32'(bus.reg_dst), 32'd1);
      step_state({tag, "_s0"}, 4'd0);
   endtask

   task automatic chk_s0_outputs(input string tag);
      chk({tag, "_state"},     32'(bus.state),     32'd0);
      chk({tag, "_finish"},    32'(bus.finish),    32'd0);
      chk({tag, "_mem_read"},  32'(bus.mem_read),  32'd1);
      chk({tag, "_ir_write"},  32'(bus.ir_write),  32'd1);
      chk({tag, "_pc_write"},  32'(bus.pc_write),  32'd1);
      chk({tag, "_alu_src_b"}, 32'(bus.alu_src_b), 32'd1);
      chk({tag, "_pc_en"},     32'(bus.pc_en),     32'd1);
      chk({tag, "_iord"},      32'(bus.iord),      32'd0);
   endtask

   initial begin
      rst_n      = 1'b1;
      bus.opcode = 6'd0;
      bus.funct  = 6'd0;
      bus.op_a   = 32'd0;
      bus.op_b   = 32'd0;
      #1 rst_n   = 1'b0;
      @(negedge clk);
      chk_s0_outputs("rst");
      rst_n = 1'b1;

      // R-type ALU operations
      r_alu("r_add", 6'b100000, 32'd5,          32'd7,          32'd12,         1'b0);
      r_alu("r_slt", 6'b101010, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0);
      r_alu("r_sub", 6'b100010, 32'd3,          32'd3,          32'd0,          1'b1);
      r_alu("r_and", 6'b100100, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0);
      r_alu("r_or",  6'b100101, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_FFF0,  1'b0);
      r_alu("r_nor", 6'b100111, 32'd0,          32'd0,          NOR_EXP,        NOR_EXP == 32'd0);

      // LW
      bus.opcode = OP_LW;
      step_state("lw_s1", 4'd1);
      step_state("lw_s2", 4'd2);
      step_state("lw_s3", 4'd3);
      chk("lw_s3_mem_read", 32'(bus.mem_read), 32'd1);
      chk("lw_s3_iord",     32'(bus.iord),     32'd1);
      step_state("lw_s4", 4'd4);
      chk("lw_s4_mem_to_reg", 32'(bus.mem_to_reg), 32'd1);
      chk("lw_s4_reg_write",  32'(bus.reg_write),  32'd1);
      chk("lw_s4_reg_dst",    32'(bus.reg_dst),    32'd0);
      step_state("lw_s0", 4'd0);

      // SW
      bus.opcode = OP_SW;
      step_state("sw_s1", 4'd1);
      chk("sw_s1_mem_write", 32'(bus.mem_write), 32'd0);
      step_state("sw_s2", 4'd2);
      chk("sw_s2_mem_write", 32'(bus.mem_write), 32'd0);
      step_state("sw_s5", 4'd5);
      chk("sw_s5_mem_write", 32'(bus.mem_write), 32'd1);
      chk("sw_s5_iord",      32'(bus.iord),      32'd1);
      step_state("sw_s0", 4'd0);
      chk("sw_s0_mem_write", 32'(bus.mem_write), 32'd0);

      // BEQ taken / not taken
      bus.opcode = OP_BEQ;
      step_state("beq_s1", 4'd1);
      bus.op_a = 32'd9;
      bus.op_b = 32'd9;
      step_state("beq_s8", 4'd8);
      chk("beq_zero",      32'(bus.zero),      32'd1);
      chk("beq_pc_en",     32'(bus.pc_en),     32'd1);
      chk("beq_pc_source", 32'(bus.pc_source), 32'd1);
      bus.op_b = 32'd8;
      #1;
      chk("beq_nt_pc_en",  32'(bus.pc_en),     32'd0);
      step_state("beq_s0", 4'd0);

      // Jump
      bus.opcode = OP_J;
      step_state("j_s1", 4'd1);
      step_state("j_s9", 4'd9);
      chk("j_pc_write",  32'(bus.pc_write),  32'd1);
      chk("j_pc_source", 32'(bus.pc_source), 32'd2);
      step_state("j_s0", 4'd0);

      // Asynchronous reset in the middle of S3
      bus.opcode = OP_LW;
      step_state("ar_s1", 4'd1);
      step_state("ar_s2", 4'd2);
      step_state("ar_s3", 4'd3);
      #2 rst_n = 1'b0;
      #1;
      chk_s0_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Illegal opcode halts until reset
      bus.opcode = 6'h3F;
      step_state("halt_s1", 4'd1);
      step_state("halt_s10", 4'd10);
      chk("halt_finish", 32'(bus.finish), 32'd1);
      for (int i = 0; i < 6; i++) begin
         step_state("halt_hold", 4'd10);
         chk("halt_hold_finish", 32'(bus.finish), 32'd1);
      end
      chk("halt_pc_write", 32'(bus.pc_write), 32'd0);
      chk("halt_mem_read", 32'(bus.mem_read), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("halt_rst_state",  32'(bus.state),  32'd0);
      chk("halt_rst_finish", 32'(bus.finish), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
